data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter that shares the single-ported data TCM between the core load/store path (port 0) and a secondary master such as debug or DMA (port 1). It sits between the requesters and the TCM and grants at most one access per cycle, round-robin by default. It supports locked multi-access sequences for atomic read-modify-write, with a lock timeout. It returns read data and a response strobe to the owning port one cycle after grant.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- LOCK_MAX, 16, maximum consecutive cycles a port may hold the lock (≥2)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_i[1:0]  in  2  access request per port
- lock_i[1:0]  in  2  keep ownership after this access
- we_i[1:0]  in  2  0 read, 1 write, per port
- addr0_i, addr1_i  in  ADDR_WIDTH  byte address per port
- be0_i, be1_i  in  4  byte enables per port
- wdata0_i, wdata1_i  in  DATA_WIDTH  write data per port
- gnt_o[1:0]  out  2  request accepted this cycle; combinational, one-hot or zero
- rvalid_o[1:0]  out  2  response strobe, one cycle after grant
- rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o of a read
- lock_err_o  out  1  one-cycle pulse on forced lock release
- mem_req_o  out  1  TCM access this cycle
- mem_we_o  out  1  TCM write enable
- mem_addr_o  out  ADDR_WIDTH  TCM address
- mem_be_o  out  4  TCM byte enables
- mem_wdata_o  out  DATA_WIDTH  TCM write data
- mem_rdata_i  in  DATA_WIDTH  TCM read data, valid the cycle after mem_req_o

## Operation
- States: IDLE, LOCK0, LOCK1.
- IDLE:
  - Single requester is granted.
  - If both ports request, the port equal to rr_ptr wins.
  - After a grant to port k, rr_ptr ← 1−k.
- Grant to port k with lock_i[k]=1 → LOCKk, and lock_cnt ← 1.
- LOCKk:
  - Only port k is eligible; the other port's gnt_o stays 0 even when it requests.
  - Each cycle, lock_cnt increments, saturating at LOCK_MAX.
  - Exit to IDLE when port k is granted with lock_i[k]=0 (that access still completes), or when req_i[k]=0 and lock_i[k]=0.
  - rr_ptr ← 1−k on exit.
- Lock timeout: in LOCKk with lock_cnt=LOCK_MAX and a lock still asserted:
  - Go to IDLE and pulse lock_err_o for one cycle.
  - Set rr_ptr ← 1−k, so the starved port wins the next tie.
  - Port k is not granted in the forced-release cycle.
- Mux:
  - mem_* carry the granted port's signals.
  - mem_req_o = |gnt_o.
  - With no grant, mem_addr_o, mem_be_o and mem_wdata_o are 0 and mem_we_o is 0.
- Response:
  - Register granted port index and we.
  - Next cycle, rvalid_o[idx]=1 for reads and writes alike.
  - rdata_o = mem_rdata_i for reads; 0 for writes and idle cycles.
- Grant does not depend on outstanding responses. Back-to-back grants every cycle are legal (fully pipelined).

## Timing
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, lock_err_o=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0.
  - state=IDLE, rr_ptr=0, lock_cnt=0.
- Grant latency is 0 cycles: gnt_o is combinational from req_i, state and rr_ptr.
- Response latency is exactly 1 cycle after gnt_o.
- A requester holds req, addr, we, be and wdata stable until gnt_o. It drops or changes them in the cycle after gnt_o.
- Reset asserted mid-sequence:
  - A pending rvalid is discarded and no response appears after reset release.
  - Lock state is cleared.
- Simultaneous events:
  - Forced release and a new request from the other port in the same cycle: the other port is granted in that cycle.
  - lock_err_o and the other port's gnt_o may both be 1 in that cycle.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - Port 0 always wins ties in IDLE and rr_ptr is not implemented.
  - Lock timeout still applies; after a forced release, port 1 is granted if requesting.
- ARB_FIXED_PRIO_EN undefined: round-robin as specified in Operation.

## Test plan
- Port 0 alone reads 0x100 (TCM word 0xDEADBEEF) → gnt_o=01 the same cycle; next cycle rvalid_o=01 and rdata_o=0xDEADBEEF.
- Both ports request every cycle with no lock, after reset → grants alternate 01, 10, 01, 10; the rvalid_o pattern is the same, delayed one cycle.
- Port 1 holds the lock for 3 accesses (read 0x200, write 0x200 with be=0001, then unlocked) while port 0 requests continuously → gnt_o=10 for 3 cycles, then port 0 is granted.
- Port 0 holds lock_i=1 with LOCK_MAX=16 and port 1 requests → lock_err_o pulses in cycle 16 after the lock grant, and port 1 is granted in that cycle.
- rst_n pulsed low in the cycle after a grant → rvalid_o is never asserted for that access, and all outputs are 0 during reset.
- With ARB_FIXED_PRIO_EN, both ports requesting for 4 cycles → gnt_o=01 on every cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing the single-ported data TCM between the core LSU (port 0)
// and a secondary master (port 1), with locked sequences and a lock timeout.
// Define ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            lock_i,
  input  logic [1:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [3:0]            be0_i,
  input  logic [3:0]            be1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  lock_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]      gnt_s;
  logic            lock_err_s;
  logic            tie_win_s;
  logic            own_s;
  logic            oth_s;
  logic            valid_q, valid_d;
  logic            idx_q, idx_d;
  logic            we_q, we_d;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_win_s = 1'b0;
`else
  logic rr_q, rr_d;

  assign tie_win_s = rr_q;

  // Round-robin pointer: points away from whoever was served or released last
  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE) begin
      if (gnt_s != 2'b00) begin
        rr_d = ~gnt_s[1];
      end else begin
        rr_d = rr_q;
      end
    end else if (state_d != state_q) begin
      rr_d = ~own_s;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign own_s = (state_q == LOCK1);
  assign oth_s = ~own_s;

  // Grant selection and lock state machine next-state logic
  always_comb begin
    gnt_s      = 2'b00;
    lock_err_s = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i[0] && (!req_i[1] || !tie_win_s)) begin
          gnt_s = 2'b01;
        end else if (req_i[1]) begin
          gnt_s = 2'b10;
        end else begin
          gnt_s = 2'b00;
        end
        if (gnt_s[0] && lock_i[0]) begin
          state_d    = LOCK0;
          lock_cnt_d = CNT_ONE;
        end else if (gnt_s[1] && lock_i[1]) begin
          state_d    = LOCK1;
          lock_cnt_d = CNT_ONE;
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        if (lock_i[own_s] && (lock_cnt_q == CNT_MAX)) begin
          // Forced release: the owner is skipped and the other port may take this slot
          lock_err_s = 1'b1;
          if (req_i[oth_s]) begin
            gnt_s[oth_s] = 1'b1;
            if (lock_i[oth_s]) begin
              state_d    = oth_s ? LOCK1 : LOCK0;
              lock_cnt_d = CNT_ONE;
            end else begin
              state_d    = IDLE;
              lock_cnt_d = '0;
            end
          end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end
        end else begin
          gnt_s[own_s] = req_i[own_s];
          if (!lock_i[own_s]) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end else if (lock_cnt_q == CNT_MAX) begin
            state_d    = state_q;
            lock_cnt_d = lock_cnt_q;
          end else begin
            state_d    = state_q;
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        gnt_s      = 2'b00;
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Arbiter state and lock counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Grants are combinational, so they are held off explicitly while reset is asserted
  assign gnt_o      = gnt_s & {2{rst_n}};
  assign lock_err_o = lock_err_s & rst_n;
  assign mem_req_o  = |gnt_o;

  // TCM request mux, zeroed when nothing is granted
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    if (gnt_o[0]) begin
      mem_we_o    = we_i[0];
      mem_addr_o  = addr0_i;
      mem_be_o    = be0_i;
      mem_wdata_o = wdata0_i;
    end else if (gnt_o[1]) begin
      mem_we_o    = we_i[1];
      mem_addr_o  = addr1_i;
      mem_be_o    = be1_i;
      mem_wdata_o = wdata1_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = 4'h0;
      mem_wdata_o = '0;
    end
  end

  assign valid_d = mem_req_o;
  assign idx_d   = gnt_o[1];
  assign we_d    = mem_we_o;

  // Response tracking: owner and direction of the access granted last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
    end
  end

  assign rvalid_o = valid_q ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_o  = (valid_q && !we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter: a driver checks grants and queues expected
// responses, a monitor pops and compares them whenever rvalid_o is raised.
module tb_data_mem_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i, lock_i, we_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [3:0]  be0_i, be1_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic        lock_err_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  typedef struct packed {
    logic [1:0]  rv;
    logic [31:0] rd;
  } resp_t;

  resp_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [0:255];
  logic [31:0] w200;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .be0_i(be0_i), .be1_i(be1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .lock_err_o(lock_err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // TCM model: one-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= mem[mem_addr_o[9:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest queued expectation
  always @(negedge clk) begin
    resp_t r;
    if (rvalid_o !== 2'b00) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid actual=%b/%h required=none", rvalid_o, rdata_o);
      end else begin
        r = exp_q.pop_front();
        chk("rvalid", {62'd0, rvalid_o}, {62'd0, r.rv});
        chk("rdata", {32'd0, rdata_o}, {32'd0, r.rd});
      end
    end
  end

  // One arbitration cycle; port 0 always uses be=F and wdata=0x55555555
  task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [3:0] be1, input logic [31:0] wd1,
                      input logic [1:0] eg, input logic eerr, input logic [31:0] erd,
                      input bit push, input logic [31:0] e_addr, input logic e_we,
                      input logic [3:0] e_be, input logic [31:0] e_wd);
    resp_t r;
    req_i = req; lock_i = lock; we_i = we;
    addr0_i = a0; addr1_i = a1; be0_i = 4'hF; be1_i = be1;
    wdata0_i = 32'h5555_5555; wdata1_i = wd1;
    @(negedge clk);
    chk("gnt", {62'd0, gnt_o}, {62'd0, eg});
    chk("lock_err", {63'd0, lock_err_o}, {63'd0, eerr});
    chk("mem_req", {63'd0, mem_req_o}, {63'd0, (eg != 2'b00)});
    chk("mem_addr_we_be_wd", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o[26:0]},
        {e_addr, e_we, e_be, e_wd[26:0]});
    if (push && eg != 2'b00) begin
      r.rv = eg;
      r.rd = erd;
      exp_q.push_back(r);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt_rvalid_err"}, {59'd0, gnt_o, rvalid_o, lock_err_o}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, rdata_o}, 64'd0);
    chk({tag, "_mem_ctl"}, {26'd0, mem_req_o, mem_we_o, mem_addr_o, mem_be_o}, 64'd0);
    chk({tag, "_mem_wdata"}, {32'd0, mem_wdata_o}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEAD_BEEF;
    mem[8'h80] = 32'h1122_3344;
    w200 = 32'h1122_3344;
    mem_rdata_i = 32'h0;
    rst_n = 1'b0; req_i = 2'b00; lock_i = 2'b00; we_i = 2'b00;
    addr0_i = 32'h0; addr1_i = 32'h0; be0_i = 4'h0; be1_i = 4'h0;
    wdata0_i = 32'h0; wdata1_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Port 0 alone reads 0x100
    step(2'b01, 2'b00, 2'b00, 32'h100, 32'h0, 4'hF, 32'h0, 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b1,
         32'h100, 1'b0, 4'hF, 32'h5555_5555);
    step(2'b00, 2'b00, 2'b00, 32'h100, 32'h0, 4'hF, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0,
         32'h0, 1'b0, 4'h0, 32'h0);

    // Reset in the cycle after a grant: that response must never appear
    step(2'b10, 2'b00, 2'b00, 32'h0, 32'h200, 4'hF, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0,
         32'h200, 1'b0, 4'hF, 32'h0);
    rst_n = 1'b0;
    req_i = 2'b11;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    req_i = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // Both ports request every cycle: round-robin alternation
    for (int i = 0; i < 4; i++) begin
      if (FIXED || (i % 2 == 0))
        step(2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b01, 1'b0, 32'hDEAD_BEEF,
             1'b1, 32'h100, 1'b0, 4'hF, 32'h5555_5555);
      else
        step(2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b10, 1'b0, w200,
             1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
    end

`ifndef ARB_FIXED_PRIO_EN
    // Port 0 alone so that port 1 owns the next tie, then port 1 locked RMW
    step(2'b01, 2'b00, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b1,
         32'h100, 1'b0, 4'hF, 32'h5555_5555);
    step(2'b11, 2'b10, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b10, 1'b0, 32'h1122_3344, 1'b1,
         32'h200, 1'b0, 4'hF, 32'h0);
    step(2'b11, 2'b10, 2'b10, 32'h100, 32'h200, 4'h1, 32'h0000_00AA, 2'b10, 1'b0, 32'h0, 1'b1,
         32'h200, 1'b1, 4'h1, 32'h0000_00AA);
    step(2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b10, 1'b0, 32'h1122_33AA, 1'b1,
         32'h200, 1'b0, 4'hF, 32'h0);
    w200 = 32'h1122_33AA;
    step(2'b01, 2'b00, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b1,
         32'h100, 1'b0, 4'hF, 32'h5555_5555);
`endif

    // Port 0 holds the lock until the timeout forces it off; port 1 takes the release cycle
    for (int i = 0; i < 16; i++) begin
      step((i == 0) ? 2'b01 : 2'b11, 2'b01, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b01, 1'b0,
           32'hDEAD_BEEF, 1'b1, 32'h100, 1'b0, 4'hF, 32'h5555_5555);
    end
    step(2'b11, 2'b01, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b10, 1'b1, w200, 1'b1,
         32'h200, 1'b0, 4'hF, 32'h0);
    step(2'b00, 2'b00, 2'b00, 32'h100, 32'h200, 4'hF, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0,
         32'h0, 1'b0, 4'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("responses_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
